// File: rtl/apb2axi.sv
// APB3 completer to AXI4-Lite manager bridge: each APB transfer becomes exactly one
// single-beat AXI-Lite transaction, and the APB access phase is stretched until the response returns.
module apb2axi #(
  parameter int                     APB_ADRW = 12,
  parameter int                     AXI_ADRW = 32,
  parameter logic [AXI_ADRW-1:0]    AXI_BASE = AXI_ADRW'(32'h8000_0000)
) (
  input  logic                aclk,
  input  logic                areset,
  // APB completer
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [APB_ADRW-1:0] paddr,
  input  logic [31:0]         pwdata,
  output logic                pready,
  output logic [31:0]         prdata,
  output logic                pslverr,
  // AXI-Lite manager
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ADRW-1:0] awaddr,
  output logic [2:0]          awprot,
  output logic                wvalid,
  input  logic                wready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [AXI_ADRW-1:0] araddr,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  // debug view of the one-hot FSM state
  output logic [5:0]          dbg_state
);

  // Handshakes: every AXI transfer completes on a rising edge where valid and ready are both
  // high; a raised valid is held, with its payload stable, until that edge.

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_WADDR = 6'b000010,
    S_WRESP = 6'b000100,
    S_RADDR = 6'b001000,
    S_RDATA = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  state_t              state_q, state_d;
  logic [AXI_ADRW-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  // Only bit 1 of a response distinguishes an error; the low bit carries no meaning here.
  logic unused_resp;
  assign unused_resp = ^{bresp[0], rresp[0]};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only the setup phase starts a transfer; a stray access phase is ignored.
        if (psel && !penable) begin
          addr_d    = AXI_BASE | AXI_ADRW'(paddr);
          wdata_d   = pwdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = pwrite ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = bresp[1];
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = rresp[1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pready  = 1'b1;
        pslverr = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign prdata    = rdata_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wstrb     = 4'hF;
  assign dbg_state = state_q;

endmodule

// File: doc/apb2axi.md
Name: apb2axi

Overview:
- APB3 completer (slave) to AXI4-Lite manager (master) bridge.
- Lets a single APB requester, such as a debug or config master, reach AXI-Lite memory space.
- Each APB transfer is converted into exactly one AXI-Lite single-beat transaction. The APB access phase is stretched with pready until the AXI response returns.
- One outstanding transaction at a time; no buffering beyond one address/data/response set.

Parameters:
- APB_ADRW, 12, APB paddr width in bits.
- AXI_ADRW, 32, AXI address width; must be >= APB_ADRW.
- AXI_BASE, 32'h80000000, base OR-ed onto the zero-extended paddr to form the AXI address; low APB_ADRW bits must be zero.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  APB_ADRW  APB byte address.
- pwdata  in  32  APB write data.
- pready  out  1  APB transfer complete.
- prdata  out  32  APB read data; valid when pready & ~pwrite.
- pslverr  out  1  APB error; valid when pready.
- awvalid/awready  out/in  1  AXI write address handshake.
- awaddr  out  AXI_ADRW  AXI write address.
- awprot  out  3  constant 3'b000.
- wvalid/wready  out/in  1  AXI write data handshake.
- wdata  out  32  AXI write data.
- wstrb  out  4  constant 4'hF.
- bvalid/bready  in/out  1  AXI write response handshake.
- bresp  in  2  AXI write response.
- arvalid/arready  out/in  1  AXI read address handshake.
- araddr  out  AXI_ADRW  AXI read address.
- arprot  out  3  constant 3'b000.
- rvalid/rready  in/out  1  AXI read data handshake.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response.

Behaviour:
- Registers:
  - one-hot state;
  - addr_r (AXI_ADRW), wdata_r (32), rdata_r (32), err_r (1);
  - aw_done, w_done flags.
- Reset: state = IDLE. All registers cleared. All AXI valid outputs, bready, rready, pready, pslverr = 0; prdata = 0.
- IDLE:
  - Starts on psel & ~penable (APB setup phase).
  - Captures addr_r = AXI_BASE | paddr, wdata_r = pwdata. Clears aw_done, w_done, err_r.
  - Next state is WADDR if pwrite, else RADDR.
  - psel & penable seen while in IDLE (protocol violation) is ignored.
- WADDR:
  - awvalid = ~aw_done; wvalid = ~w_done; awaddr = addr_r; wdata = wdata_r.
  - awvalid & awready sets aw_done; wvalid & wready sets w_done. Either order or the same cycle is legal.
  - Exits to WRESP in the cycle in which both are complete (registered or current-cycle handshake).
  - Valid is never dropped before its handshake; AW and W are each issued exactly once.
- WRESP: bready = 1. On bvalid: err_r = bresp[1], go to DONE.
- RADDR: arvalid = 1, araddr = addr_r. On arready, go to RDATA.
- RDATA: rready = 1. On rvalid: rdata_r = rdata, err_r = rresp[1], go to DONE.
- DONE:
  - pready = 1, pslverr = err_r, prdata = rdata_r (rdata_r unchanged on writes).
  - Lasts exactly one cycle, then IDLE.
- pready is 0 in every state except DONE. pslverr is 0 whenever pready is 0.
- Minimum latency, with the AXI side always ready/valid and setup sampled at cycle 0:
  - write: AW+W in cycle 1, B in cycle 2, pready in cycle 3;
  - read: AR in cycle 1, R in cycle 2, pready in cycle 3.
- Back-to-back transfers: APB requires a setup cycle, so the next transfer starts in the IDLE cycle after DONE. No transfer is dropped.
- OKAY (00) and EXOKAY (01) map to pslverr = 0; SLVERR (10) and DECERR (11) map to pslverr = 1. Read data is forwarded even on error.
- No timeout: a stalled AXI completer stalls APB indefinitely.
- Reset mid-operation: the bridge immediately returns to IDLE with all valids low and the in-flight AXI transaction abandoned. Both sides are reset together.
- awaddr/araddr/wdata remain stable while their valid is high.

Test Plan:
- Write, AXI always ready: paddr=12'h010, pwdata=32'hDEADBEEF -> awaddr=32'h80000010, wdata=DEADBEEF, wstrb=F in cycle 1. bvalid/OKAY in cycle 2. pready=1, pslverr=0 in cycle 3 only.
- Read, arready delayed 3 cycles, rvalid delayed 2 cycles, rdata=32'h12345678 -> arvalid held stable 4 cycles. pready high for 1 cycle with prdata=32'h12345678.
- Write with AW accepted 2 cycles after W (wready=1, awready late) -> wvalid drops after its handshake, awvalid held. Exactly one AW and one W handshake; B accepted afterwards.
- Read with rresp=2'b10 -> pslverr=1 with pready. Following write with bresp=2'b00 -> pslverr=0.
- Two back-to-back APB writes then a read (setup cycle immediately after each pready) -> three AXI transactions in order, none lost, addresses and data matching.
- areset asserted during WRESP with bvalid held low -> next cycle IDLE, bready=0, pready=0. A new read after reset completes normally.
